// File: rtl/mf_pkg.sv
// Shared definitions for the Multiface-style paging device: FSM states,
// default parameter values and shadow-RAM target addresses.
package mf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PENDING,
      ST_PAGED,
      ST_PAGED_H,
      ST_HIDDEN
   } mf_state_t;

   localparam logic [15:0] DEF_PAGE_PORT   = 16'hFEE8;
   localparam logic [15:0] DEF_NMI_ADDR    = 16'h0066;
   localparam logic [15:0] DEF_HIDE_ADDR   = 16'h0065;
   localparam bit          DEF_SHADOW_EN   = 1'b1;
   localparam logic [15:0] DEF_NMI_TIMEOUT = 16'd4096;

   // I/O port high bytes whose writes are mirrored into RAM
   localparam logic [7:0] PFX_GA       = 8'h7F;
   localparam logic [7:0] PFX_CRTC_SEL = 8'hBC;
   localparam logic [7:0] PFX_CRTC_DAT = 8'hBD;
   localparam logic [7:0] PFX_PPI      = 8'hF7;
   localparam logic [7:0] PFX_ROM      = 8'hDF;

   localparam logic [12:0] SH_PAL_SEL    = 13'h1FCF;
   localparam logic [12:0] SH_PAL_BORDER = 13'h1FDF;
   localparam logic [12:0] SH_PAL_BASE   = 13'h1F90;
   localparam logic [12:0] SH_MODE       = 13'h1FEF;
   localparam logic [12:0] SH_MMR        = 13'h1FFF;
   localparam logic [12:0] SH_CRTC_SEL   = 13'h1CFF;
   localparam logic [12:0] SH_CRTC_BASE  = 13'h1DB0;
   localparam logic [12:0] SH_PPI        = 13'h17FF;
   localparam logic [12:0] SH_ROMSEL     = 13'h1AAC;

endpackage

// File: rtl/mf_interface_if.sv
// CPU-side bus of the paging device: strobes, address/data in, and the
// device's NMI, mapping and read-data outputs.
interface mf_interface_if;

   logic        m1;
   logic        io_wr;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;

   logic        nmi;
   logic        rom_en;
   logic        ram_en;
   logic [7:0]  dout;
   logic        active;

   modport master (
      output m1, io_wr, mem_rd, mem_wr, cpu_addr, cpu_dout,
      input  nmi, rom_en, ram_en, dout, active
   );

   modport slave (
      input  m1, io_wr, mem_rd, mem_wr, cpu_addr, cpu_dout,
      output nmi, rom_en, ram_en, dout, active
   );

endinterface

// File: rtl/mf_shadow_decode.sv
// Maps a hardware-register I/O write to the RAM location that mirrors it,
// and flags writes that update the pen / CRTC register selectors.
module mf_shadow_decode
   import mf_pkg::*;
#(
   parameter bit SHADOW_EN = DEF_SHADOW_EN
) (
   input  logic [7:0]  port,
   input  logic [7:0]  data,
   input  logic [4:0]  pen,
   input  logic [3:0]  crtc_reg,
   output logic        store,
   output logic [12:0] addr,
   output logic        pen_ld,
   output logic        crtc_ld
);

   logic unused_data;
   assign unused_data = data[5];

   always_comb begin
      store   = 1'b0;
      addr    = '0;
      pen_ld  = 1'b0;
      crtc_ld = 1'b0;
      if (SHADOW_EN) begin
         case (port)
            PFX_GA: begin
               store = 1'b1;
               case (data[7:6])
                  2'b00: begin
                     addr   = SH_PAL_SEL;
                     pen_ld = 1'b1;
                  end
                  2'b01:   addr = pen[4] ? SH_PAL_BORDER : SH_PAL_BASE + {9'b0, pen[3:0]};
                  2'b10:   addr = SH_MODE;
                  default: addr = SH_MMR;
               endcase
            end
            PFX_CRTC_SEL: begin
               store   = 1'b1;
               addr    = SH_CRTC_SEL;
               crtc_ld = 1'b1;
            end
            PFX_CRTC_DAT: begin
               store = 1'b1;
               addr  = SH_CRTC_BASE + {9'b0, crtc_reg};
            end
            PFX_PPI: begin
               store = 1'b1;
               addr  = SH_PPI;
            end
            PFX_ROM: begin
               store = 1'b1;
               addr  = SH_ROMSEL;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mf_interface.sv
// Multiface-style stop-button device: NMI/paging state machine, 8 KB
// internal RAM with write-through read register, and register shadowing.
module mf_interface
   import mf_pkg::*;
#(
   parameter logic [15:0] PAGE_PORT   = DEF_PAGE_PORT,
   parameter logic [15:0] NMI_ADDR    = DEF_NMI_ADDR,
   parameter logic [15:0] HIDE_ADDR   = DEF_HIDE_ADDR,
   parameter bit          SHADOW_EN   = DEF_SHADOW_EN,
   parameter logic [15:0] NMI_TIMEOUT = DEF_NMI_TIMEOUT
) (
   input  logic           clk_sys,
   input  logic           reset,
   input  logic           enable,
   input  logic           key_nmi,
   mf_interface_if.slave  bus
);

   logic        key_q, m1_q, io_wr_q;
   logic        key_rise, m1_rise, io_rise;
   logic        port_hit, page_in, page_out;

   mf_state_t   state, state_nx;
   mf_state_t   ret_state, ret_state_nx;
   logic [15:0] cnt, cnt_nx;

   logic [4:0]  pen;
   logic [3:0]  crtc_reg;
   logic        sh_store, sh_pen_ld, sh_crtc_ld;
   logic [12:0] sh_addr;

   logic [7:0]  ram [0:8191];
   logic [7:0]  rd_q;
   logic        we;
   logic [12:0] wa;
   logic [7:0]  wd;

   logic        paged;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         key_q   <= 1'b0;
         m1_q    <= 1'b0;
         io_wr_q <= 1'b0;
      end else begin
         key_q   <= key_nmi;
         m1_q    <= bus.m1;
         io_wr_q <= bus.io_wr;
      end
   end

   assign key_rise = key_nmi & ~key_q;
   assign m1_rise  = bus.m1 & ~m1_q;
   assign io_rise  = bus.io_wr & ~io_wr_q;

   assign port_hit = io_rise && (bus.cpu_addr[15:2] == PAGE_PORT[15:2]);
   assign page_in  = port_hit & ~bus.cpu_addr[1];
   assign page_out = port_hit & bus.cpu_addr[1];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= ST_IDLE;
         ret_state <= ST_IDLE;
         cnt       <= '0;
      end else begin
         state     <= state_nx;
         ret_state <= ret_state_nx;
         cnt       <= cnt_nx;
      end
   end

   // ret_state remembers IDLE vs HIDDEN so an unanswered NMI can fall back
   always_comb begin
      state_nx     = state;
      ret_state_nx = ret_state;
      cnt_nx       = cnt;
      if (!enable) begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_rise) begin
                  ret_state_nx = ST_IDLE;
                  state_nx     = ST_PENDING;
                  cnt_nx       = '0;
               end else if (page_in) begin
                  state_nx = ST_PAGED;
               end
            end
            ST_PENDING: begin
               if (m1_rise && bus.cpu_addr == NMI_ADDR) begin
                  state_nx = ST_PAGED;
                  cnt_nx   = '0;
               end else if (NMI_TIMEOUT != '0 && cnt == NMI_TIMEOUT - 16'd1) begin
                  state_nx = ret_state;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 16'd1;
               end
            end
            ST_PAGED: begin
               if (m1_rise && bus.cpu_addr == HIDE_ADDR) state_nx = ST_PAGED_H;
               else if (page_out)                         state_nx = ST_IDLE;
            end
            ST_PAGED_H: begin
               if (page_out) state_nx = ST_HIDDEN;
            end
            ST_HIDDEN: begin
               if (key_rise) begin
                  ret_state_nx = ST_HIDDEN;
                  state_nx     = ST_PENDING;
                  cnt_nx       = '0;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   mf_shadow_decode #(
      .SHADOW_EN (SHADOW_EN)
   ) u_shadow (
      .port     (bus.cpu_addr[15:8]),
      .data     (bus.cpu_dout),
      .pen      (pen),
      .crtc_reg (crtc_reg),
      .store    (sh_store),
      .addr     (sh_addr),
      .pen_ld   (sh_pen_ld),
      .crtc_ld  (sh_crtc_ld)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pen      <= '0;
         crtc_reg <= '0;
      end else if (enable && io_rise) begin
         if (sh_pen_ld)  pen      <= bus.cpu_dout[4:0];
         if (sh_crtc_ld) crtc_reg <= bus.cpu_dout[3:0];
      end
   end

   assign paged       = (state == ST_PAGED) || (state == ST_PAGED_H);
   assign bus.active  = enable & paged;
   assign bus.nmi     = enable & (state == ST_PENDING);
   assign bus.rom_en  = bus.active & (bus.cpu_addr[15:13] == 3'b000);
   assign bus.ram_en  = bus.active & (bus.cpu_addr[15:13] == 3'b001);
   assign bus.dout    = (bus.ram_en & bus.mem_rd) ? rd_q : 8'hFF;

   // A page-port write blocks every RAM write that cycle; shadow beats CPU
   always_comb begin
      we = 1'b0;
      wa = bus.cpu_addr[12:0];
      wd = bus.cpu_dout;
      if (!reset && enable && !port_hit) begin
         if (io_rise && sh_store) begin
            we = 1'b1;
            wa = sh_addr;
         end else if (bus.mem_wr && bus.ram_en) begin
            we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (we) ram[wa] <= wd;
      rd_q <= we ? wd : ram[bus.cpu_addr[12:0]];
   end

endmodule

// File: tb/tb_mf_interface.sv
// Directed bench for mf_interface: an event-level model checks outputs on
// every cycle, and literal expectations pin the key scenarios.
module tb_mf_interface;

   logic clk = 1'b0;
   logic reset, enable, key_nmi;

   mf_interface_if bus();

   mf_interface #(
      .PAGE_PORT   (16'hFEE8),
      .NMI_ADDR    (16'h0066),
      .HIDE_ADDR   (16'h0065),
      .SHADOW_EN   (1'b1),
      .NMI_TIMEOUT (16'd16)
   ) dut (
      .clk_sys (clk),
      .reset   (reset),
      .enable  (enable),
      .key_nmi (key_nmi),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_WAIT, M_ON, M_ON_HIDE, M_OFF} mmode_t;
   mmode_t     mode = M_IDLE, back = M_IDLE;
   int         waited = 0;
   logic [4:0] m_pen;
   logic [3:0] m_crtc;
   logic [7:0] mram [8192];
   bit         mknown [8192];
   logic [7:0] lw;
   bit         lw_known = 0;
   logic       pk, pm, pw;
   bit         model_ok = 0;

   function automatic void m_shadow(input logic [15:0] a, input logic [7:0] d,
                                    input logic [4:0] p, input logic [3:0] c,
                                    output bit hit, output logic [12:0] ta);
      hit = 1;
      ta  = '0;
      case (a[15:8])
         8'h7F: case (d[7:6])
                   2'd0:    ta = 13'h1FCF;
                   2'd1:    ta = p[4] ? 13'h1FDF : 13'h1F90 + 13'(p[3:0]);
                   2'd2:    ta = 13'h1FEF;
                   default: ta = 13'h1FFF;
                endcase
         8'hBC:   ta = 13'h1CFF;
         8'hBD:   ta = 13'h1DB0 + 13'(c);
         8'hF7:   ta = 13'h17FF;
         8'hDF:   ta = 13'h1AAC;
         default: hit = 0;
      endcase
   endfunction

   always @(posedge clk) begin : mdl
      bit kr, mr, wr, hit, pin, pout, sh, wen, on;
      logic [12:0] ta, wa;
      kr   = key_nmi && !pk;
      mr   = bus.m1 && !pm;
      wr   = bus.io_wr && !pw;
      hit  = wr && ((bus.cpu_addr & 16'hFFFC) == 16'hFEE8);
      pin  = hit && !bus.cpu_addr[1];
      pout = hit && bus.cpu_addr[1];
      on   = enable && (mode == M_ON || mode == M_ON_HIDE);
      m_shadow(bus.cpu_addr, bus.cpu_dout, m_pen, m_crtc, sh, ta);
      wen = 0;
      wa  = bus.cpu_addr[12:0];
      if (!reset && enable && !hit) begin
         if (wr && sh) begin
            wen = 1;
            wa  = ta;
         end else if (bus.mem_wr && on && bus.cpu_addr[15:13] == 3'b001) begin
            wen = 1;
         end
      end
      if (wen) begin
         mram[wa]   = bus.cpu_dout;
         mknown[wa] = 1;
         lw         = bus.cpu_dout;
         lw_known   = 1;
      end else begin
         lw       = mram[bus.cpu_addr[12:0]];
         lw_known = mknown[bus.cpu_addr[12:0]];
      end
      if (reset) begin
         pk = 0; pm = 0; pw = 0;
         mode = M_IDLE; back = M_IDLE; waited = 0;
         m_pen = '0; m_crtc = '0;
         model_ok = 1;
      end else begin
         pk = key_nmi; pm = bus.m1; pw = bus.io_wr;
         if (enable && wr && bus.cpu_addr[15:8] == 8'h7F && bus.cpu_dout[7:6] == 2'b00)
            m_pen = bus.cpu_dout[4:0];
         if (enable && wr && bus.cpu_addr[15:8] == 8'hBC)
            m_crtc = bus.cpu_dout[3:0];
         if (!enable) begin
            mode = M_IDLE;
            waited = 0;
         end else begin
            case (mode)
               M_IDLE:    if (kr) begin back = M_IDLE; mode = M_WAIT; waited = 0; end
                          else if (pin) mode = M_ON;
               M_WAIT:    if (mr && bus.cpu_addr == 16'h0066) mode = M_ON;
                          else begin
                             waited++;
                             if (waited == 16) mode = back;
                          end
               M_ON:      if (mr && bus.cpu_addr == 16'h0065) mode = M_ON_HIDE;
                          else if (pout) mode = M_IDLE;
               M_ON_HIDE: if (pout) mode = M_OFF;
               M_OFF:     if (kr) begin back = M_OFF; mode = M_WAIT; waited = 0; end
               default:   mode = M_IDLE;
            endcase
         end
      end
   end

   always @(negedge clk) begin : cmp
      bit on, ram_hit;
      if (model_ok) begin
         on      = enable && (mode == M_ON || mode == M_ON_HIDE);
         ram_hit = on && bus.cpu_addr[15:13] == 3'b001;
         check("nmi", bus.nmi, enable && mode == M_WAIT);
         check("active", bus.active, on);
         check("rom_en", bus.rom_en, on && bus.cpu_addr[15:13] == 3'b000);
         check("ram_en", bus.ram_en, ram_hit);
         if (ram_hit && bus.mem_rd) begin
            if (lw_known) check("dout", bus.dout, lw);
         end else begin
            check("dout", bus.dout, 8'hFF);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic io_out(input logic [15:0] a, input logic [7:0] d);
      bus.cpu_addr = a; bus.cpu_dout = d; bus.io_wr = 1; tick();
      bus.io_wr = 0; tick();
   endtask

   task automatic m1_fetch(input logic [15:0] a);
      bus.cpu_addr = a; bus.m1 = 1; tick();
      bus.m1 = 0; tick();
   endtask

   task automatic read_chk(input string nm, input logic [15:0] a, input logic [7:0] e);
      bus.cpu_addr = a; bus.mem_rd = 1; tick();
      check(nm, bus.dout, e);
      bus.mem_rd = 0; tick();
   endtask

   logic [15:0] sh_port [8] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                                16'h7F00, 16'h7F00, 16'hF700, 16'hDF00};
   logic [7:0]  sh_data [8] = '{8'h03, 8'h45, 8'h10, 8'h54, 8'h8C, 8'hC1, 8'h82, 8'h07};
   logic [15:0] sh_rd   [8] = '{16'h3FCF, 16'h3F93, 16'h3FCF, 16'h3FDF,
                                16'h3FEF, 16'h3FFF, 16'h37FF, 16'h3AAC};

   initial begin
      int n;
      reset = 1; enable = 1; key_nmi = 0;
      bus.m1 = 0; bus.io_wr = 0; bus.mem_rd = 0; bus.mem_wr = 0;
      bus.cpu_addr = '0; bus.cpu_dout = '0;
      tick(); tick(); tick();
      reset = 0; tick();
      check("rst_nmi", bus.nmi, 1'b0);
      check("rst_active", bus.active, 1'b0);
      check("rst_rom_en", bus.rom_en, 1'b0);
      check("rst_ram_en", bus.ram_en, 1'b0);
      check("rst_dout", bus.dout, 8'hFF);

      // stop press, NMI accepted at 0066
      key_nmi = 1; tick();
      check("stop_nmi", bus.nmi, 1'b1);
      key_nmi = 0; tick();
      bus.cpu_addr = 16'h0066; bus.m1 = 1; #1;
      check("nmi_before_m1", bus.nmi, 1'b1);
      tick();
      check("nmi_after_m1", bus.nmi, 1'b0);
      check("paged_active", bus.active, 1'b1);
      bus.m1 = 0; bus.cpu_addr = 16'h0100; #1;
      check("rom_en_0100", bus.rom_en, 1'b1);
      check("ram_en_0100", bus.ram_en, 1'b0);
      tick();

      // CRTC shadowing and readback
      io_out(16'hBC00, 8'h06);
      io_out(16'hBD00, 8'h27);
      check("model_1cff", mram[13'h1CFF], 8'h06);
      check("model_1db6", mram[13'h1DB6], 8'h27);
      read_chk("rd_3db6", 16'h3DB6, 8'h27);
      read_chk("rd_3cff", 16'h3CFF, 8'h06);
      for (int i = 0; i < 8; i++) begin
         io_out(sh_port[i] | 16'h0000, sh_data[i]);
         read_chk("shadow_rd", sh_rd[i], sh_data[i]);
      end

      // CPU write with write-through, ROM area writes not stored
      bus.cpu_addr = 16'h2010; bus.cpu_dout = 8'h5A; bus.mem_wr = 1; bus.mem_rd = 1; tick();
      check("wt_dout", bus.dout, 8'h5A);
      bus.mem_wr = 0; tick();
      check("wt_reread", bus.dout, 8'h5A);
      bus.mem_rd = 0;
      bus.cpu_addr = 16'h2000; bus.cpu_dout = 8'h11; bus.mem_wr = 1; tick();
      bus.mem_wr = 0; tick();

      // hide sequence
      m1_fetch(16'h0065);
      check("hide_armed_active", bus.active, 1'b1);
      io_out(16'hFEEA, 8'h00);
      check("hidden_active", bus.active, 1'b0);
      io_out(16'hFEE8, 8'h00);
      check("hidden_ignores_in", bus.active, 1'b0);
      key_nmi = 1; tick();
      check("hidden_stop_nmi", bus.nmi, 1'b1);
      key_nmi = 0; tick();
      m1_fetch(16'h0066);
      check("hidden_nmi_paged", bus.active, 1'b1);
      io_out(16'hFEEA, 8'h00);
      check("page_out_idle", bus.active, 1'b0);

      // NMI timeout without acknowledge
      key_nmi = 1; tick();
      key_nmi = 0;
      n = 0;
      if (bus.nmi) n++;
      for (int i = 0; i < 40 && bus.nmi; i++) begin
         tick();
         if (bus.nmi) n++;
      end
      check("timeout_cycles", 16'(n), 16'd16);
      check("timeout_nmi_low", bus.nmi, 1'b0);
      io_out(16'hFEE8, 8'h00);
      check("timeout_back_idle", bus.active, 1'b1);
      io_out(16'hFEEA, 8'h00);

      // same-cycle page-in and memory write: RAM write dropped
      bus.cpu_addr = 16'hFEE8; bus.cpu_dout = 8'h99; bus.io_wr = 1; bus.mem_wr = 1; tick();
      check("same_cycle_paged", bus.active, 1'b1);
      bus.io_wr = 0; bus.mem_wr = 0; tick();
      read_chk("rd_2000_kept", 16'h2000, 8'h11);

      // enable removed while paged
      bus.cpu_addr = 16'h2000; bus.mem_rd = 1; tick();
      check("pre_disable_dout", bus.dout, 8'h11);
      enable = 0; #1;
      check("disable_dout", bus.dout, 8'hFF);
      check("disable_active", bus.active, 1'b0);
      tick();
      enable = 1; tick();
      check("reenable_idle", bus.active, 1'b0);
      bus.mem_rd = 0;
      io_out(16'hFEE8, 8'h00);
      read_chk("retained_3db6", 16'h3DB6, 8'h27);

      // reset while paged: no write, latches cleared, RAM kept
      reset = 1; bus.cpu_addr = 16'h2000; bus.cpu_dout = 8'h77; bus.mem_wr = 1; tick();
      reset = 0; bus.mem_wr = 0; tick();
      check("reset_idle", bus.active, 1'b0);
      io_out(16'h7F00, 8'h45);
      io_out(16'hFEE8, 8'h00);
      read_chk("reset_no_write", 16'h2000, 8'h11);
      read_chk("reset_pen0", 16'h3F90, 8'h45);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
